// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared widths and fetch-entry type for the front end
package mips_pkg;

    localparam int XLEN    = 32;
    localparam int INSTR_W = 32;
    localparam int PC_STEP = 4;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [XLEN-1:0]    pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - instruction queue between fetch and decode
//
// Ports:
//   clk, reset      clock, asynchronous active-low reset
//   push, push_data write one fetch entry
//   pop             retire the head entry (ignored when empty)
//   flush           empty the queue; wins over push and pop
//   head            head entry, combinational
//   count           number of valid entries
module fetch_fifo
    import mips_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  fetch_entry_t               push_data,
    input  logic                       pop,
    input  logic                       flush,
    output fetch_entry_t               head,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PW = $clog2(DEPTH);

    fetch_entry_t    mem [DEPTH];
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    logic            do_pop;

    // Pointers wrap explicitly so non-power-of-two depths work.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // The producer reserves a slot at issue time, so push never needs a full check.
    assign do_pop = pop & (count != '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= ptr_inc(wr_ptr);
            if (do_pop)
                rd_ptr <= ptr_inc(rd_ptr);
            case ({push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush)
            mem[wr_ptr] <= push_data;
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch with queued decode handoff and redirect
//
// Ports:
//   clk, reset                   clock, asynchronous active-low reset
//   imem_req, imem_addr          fetch request and word-aligned address
//   imem_rdata                   instruction data, one cycle after an issued request
//   redirect_valid, redirect_pc  redirect pulse and target from execute
//   if_valid, if_instr, if_pc    head instruction offered to decode
//   id_ready                     decode accepts the head
//   stat_fetched, stat_flushed   only with FETCH_STATS_EN: pop and flush counters
//
// Optional feature macro: FETCH_STATS_EN
module fetch_stage
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    input  logic        id_ready
`ifdef FETCH_STATS_EN
    ,
    output logic [31:0] stat_fetched,
    output logic [31:0] stat_flushed
`endif
);

    localparam int CW = $clog2(DEPTH + 1);

    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] req_pc;
    logic            inflight;
    logic [CW-1:0]   count;
    logic [CW:0]     occupancy;
    logic            pop;
    logic            push;
    logic [XLEN-1:0] redirect_target;
    fetch_entry_t    head;
    fetch_entry_t    push_data;

    assign redirect_target = redirect_pc & ~32'h3;

    assign if_valid = (count != '0) & ~redirect_valid;
    assign pop      = if_valid & id_ready;

    // Slots already promised: queued entries plus the response on its way,
    // minus the one decode takes this cycle.
    assign occupancy = {1'b0, count} + (CW+1)'(inflight) - (CW+1)'(pop);
    assign imem_req  = reset & ~redirect_valid & (occupancy < (CW+1)'(DEPTH));
    assign imem_addr = fetch_pc;

    // A response arriving in the redirect cycle belongs to the old path.
    assign push      = inflight & ~redirect_valid;
    assign push_data = '{instr: imem_rdata, pc: req_pc};

    assign if_instr = head.instr;
    assign if_pc    = head.pc;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc <= RESET_PC & ~32'h3;
            req_pc   <= '0;
            inflight <= 1'b0;
        end else begin
            inflight <= imem_req;
            if (imem_req)
                req_pc <= fetch_pc;
            if (redirect_valid)
                fetch_pc <= redirect_target;
            else if (imem_req)
                fetch_pc <= fetch_pc + XLEN'(PC_STEP);
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .flush     (redirect_valid),
        .head      (head),
        .count     (count)
    );

`ifdef FETCH_STATS_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stat_fetched <= '0;
            stat_flushed <= '0;
        end else begin
            if (pop)
                stat_fetched <= stat_fetched + 32'd1;
            if (redirect_valid)
                stat_flushed <= stat_flushed + 32'(count) + 32'(inflight);
        end
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - randomized self-checking bench for fetch_stage
module tb_fetch_stage;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          DEPTH    = 2;

    logic        clk;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        id_ready;
`ifdef FETCH_STATS_EN
    logic [31:0] stat_fetched;
    logic [31:0] stat_flushed;
`endif

    fetch_stage #(
        .RESET_PC (RESET_PC),
        .DEPTH    (DEPTH)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_valid       (if_valid),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .id_ready       (id_ready)
`ifdef FETCH_STATS_EN
        ,
        .stat_fetched   (stat_fetched),
        .stat_flushed   (stat_flushed)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: every issued address becomes a token that decode must see,
    // in order, two cycles after issue, unless a redirect or reset drops it.
    typedef struct {
        logic [31:0] pc;
        int          cyc;
    } tok_t;

    tok_t        q[$];
    int          cyc;
    logic [31:0] exp_req;
    logic [31:0] mem_key;
    int          n_req;
    int          n_pop;
    int          n_checks;
    int          n_pass;
    int          m_fetched;
    int          m_flushed;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    endtask

    task automatic cycle_step();
        logic        exp_valid;
        logic        exp_issue;
        logic        pop;
        logic        req_s;
        logic [31:0] addr_s;
        int          outst;
        req_s  = 1'b0;
        addr_s = '0;
        @(negedge clk);
        if (!reset) begin
            check("rst_if_valid", {31'd0, if_valid}, 32'd0);
            check("rst_imem_req", {31'd0, imem_req}, 32'd0);
            q.delete();
            exp_req   = RESET_PC;
            m_fetched = 0;
            m_flushed = 0;
        end else begin
`ifdef FETCH_STATS_EN
            check("stat_fetched", stat_fetched, 32'(m_fetched));
            check("stat_flushed", stat_flushed, 32'(m_flushed));
`endif
            exp_valid = 1'b0;
            if (!redirect_valid && q.size() > 0)
                exp_valid = (q[0].cyc <= cyc - 2);
            check("if_valid", {31'd0, if_valid}, {31'd0, exp_valid});
            if (exp_valid) begin
                check("if_pc", if_pc, q[0].pc);
                check("if_instr", if_instr, q[0].pc ^ mem_key);
            end
            pop       = exp_valid & id_ready;
            outst     = q.size() - (pop ? 1 : 0);
            exp_issue = !redirect_valid && (outst < DEPTH);
            check("imem_req", {31'd0, imem_req}, {31'd0, exp_issue});
            if (imem_req && exp_issue)
                check("imem_addr", imem_addr, exp_req);
            req_s  = imem_req;
            addr_s = imem_addr;
            n_req += int'(imem_req);
            n_pop += int'(pop);
            if (redirect_valid) begin
                m_flushed += q.size();
                q.delete();
                exp_req = redirect_pc & ~32'h3;
            end else begin
                if (pop) begin
                    void'(q.pop_front());
                    m_fetched++;
                end
                if (exp_issue) begin
                    q.push_back('{exp_req, cyc});
                    exp_req = exp_req + 32'd4;
                end
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        imem_rdata = req_s ? (addr_s ^ mem_key) : $urandom;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++)
            cycle_step();
    endtask

    initial begin
        int p0;
        reset          = 1'b0;
        id_ready       = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        imem_rdata     = '0;
        mem_key        = '0;
        exp_req        = RESET_PC;
        cyc            = 0;
        n_req          = 0;
        n_pop          = 0;
        n_checks       = 0;
        n_pass         = 0;
        m_fetched      = 0;
        m_flushed      = 0;

        run(2);
        reset = 1'b1;
        cyc   = 0;

        // Streaming: one pop per cycle from cycle 2 on.
        p0 = n_pop;
        run(10);
        check("throughput_pops", 32'(n_pop - p0), 32'd8);

        // Back-pressure from a fresh reset.
        reset    = 1'b0;
        id_ready = 1'b0;
        run(1);
        reset = 1'b1;
        p0    = n_req;
        run(6);
        check("stall_reqs", 32'(n_req - p0), 32'(DEPTH));
        id_ready = 1'b1;
        run(8);

        // Misaligned redirect target is word-aligned.
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0043;
        run(1);
        redirect_valid = 1'b0;
        check("redir_align", imem_addr, 32'h0000_0040);
        run(6);

        // Address wrap at the top of memory.
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFF4;
        run(1);
        redirect_valid = 1'b0;
        run(8);

        // Randomized traffic with one asynchronous reset in the middle.
        for (int i = 0; i < 400; i++) begin
            id_ready       = ($urandom_range(0, 3) != 0);
            redirect_valid = ($urandom_range(0, 15) == 0);
            redirect_pc    = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                         : $urandom;
            if (i == 200) begin
                reset = 1'b0;
                #1;
                check("async_rst_if_valid", {31'd0, if_valid}, 32'd0);
                mem_key = 32'h5A5A_1234;
                run(2);
                reset = 1'b1;
            end
            cycle_step();
        end
        redirect_valid = 1'b0;
        id_ready       = 1'b1;
        run(4);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
